// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fwd_en,
  input  logic [REG_ADDR_W-1:0] src1_ID,
  input  logic [REG_ADDR_W-1:0] src2_ID,
  input  logic                  two_src_ID,
  input  logic [REG_ADDR_W-1:0] dest_EXE,
  input  logic                  WB_EN_EXE,
  input  logic                  MEM_R_EN_EXE,
  input  logic [REG_ADDR_W-1:0] dest_MEM,
  input  logic                  WB_EN_MEM,
  input  logic                  branch_taken_EXE,
  input  logic                  mem_req_MEM,
  input  logic                  mem_ready,
  output logic                  stall_IF,
  output logic                  stall_ID,
  output logic                  bubble_EXE,
  output logic                  freeze,
  output logic                  flush_IF_ID,
  output logic                  flush_ID_EXE,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              match_exe, match_mem, hz, timeout_hit, freeze_c;

  always_comb begin
    // r0 is hardwired to zero, so it never carries a real dependency
    match_exe   = (|dest_EXE) && ((src1_ID == dest_EXE) || (two_src_ID && (src2_ID == dest_EXE)));
    match_mem   = (|dest_MEM) && ((src1_ID == dest_MEM) || (two_src_ID && (src2_ID == dest_MEM)));
    hz          = fwd_en ? (WB_EN_EXE && MEM_R_EN_EXE && match_exe)
                         : ((WB_EN_EXE && match_exe) || (WB_EN_MEM && match_mem));
    timeout_hit = (state == MEM_WAIT) && !mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    freeze_c    = (state == RUN) ? (mem_req_MEM && !mem_ready) : (!mem_ready && !timeout_hit);
  end

  always_comb begin
    stall_IF     = 1'b0;
    stall_ID     = 1'b0;
    bubble_EXE   = 1'b0;
    freeze       = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EXE = 1'b0;
    mem_timeout  = 1'b0;
    if (rst_n) begin
      mem_timeout = timeout_hit;
      if (freeze_c) begin
        freeze   = 1'b1;
        stall_IF = 1'b1;
        stall_ID = 1'b1;
      end else if (branch_taken_EXE) begin
        flush_IF_ID  = 1'b1;
        flush_ID_EXE = 1'b1;
      end else if (hz) begin
        stall_IF   = 1'b1;
        stall_ID   = 1'b1;
        bubble_EXE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req_MEM && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready || timeout_hit) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall_IF && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] STALL = 7'b1110000;
  localparam logic [6:0] FRZ   = 7'b1101000;
  localparam logic [6:0] FLUSH = 7'b0000110;
  localparam logic [6:0] TMO   = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fwd_en, two_src_ID, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM;
  logic       branch_taken_EXE, mem_req_MEM, mem_ready;
  logic [4:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic       stall_IF, stall_ID, bubble_EXE, freeze, flush_IF_ID, flush_ID_EXE, mem_timeout;
  logic [15:0] stall_cycles;

  typedef struct packed {
    logic [6:0]  o;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = '0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
    .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
    .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM),
    .branch_taken_EXE(branch_taken_EXE), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_EXE(bubble_EXE), .freeze(freeze),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EXE(flush_ID_EXE), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic fwd, input logic [4:0] s1, input logic [4:0] s2, input logic two,
                        input logic [4:0] de, input logic wbe, input logic mre,
                        input logic [4:0] dm, input logic wbm,
                        input logic br, input logic req, input logic rdy);
    fwd_en = fwd; src1_ID = s1; src2_ID = s2; two_src_ID = two;
    dest_EXE = de; WB_EN_EXE = wbe; MEM_R_EN_EXE = mre;
    dest_MEM = dm; WB_EN_MEM = wbm;
    branch_taken_EXE = br; mem_req_MEM = req; mem_ready = rdy;
  endtask

  task automatic idle();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic mem(input logic req, input logic rdy, input logic br);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, br, req, rdy);
  endtask

  // one cycle: push the expectation for the driven inputs, compare mid-cycle, advance
  task automatic cyc(input string tag, input logic [6:0] exp_o);
    exp_t e;
    sb.push_back('{o: exp_o, cnt: exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "_out"}, {25'd0, stall_IF, stall_ID, bubble_EXE, freeze, flush_IF_ID, flush_ID_EXE, mem_timeout}, {25'd0, e.o});
    check({tag, "_cnt"}, {16'd0, stall_cycles}, {16'd0, e.cnt});
    @(posedge clk);
    #1;
    if (rst_n && e.o[6] && exp_cnt != 16'hFFFF) exp_cnt++;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with a load-use hazard on the inputs: outputs must stay low
    set_in(1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 1, 0);
    cyc("reset", NONE);
    rst_n = 1'b1;

    set_in(1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1);
    cyc("loaduse", STALL);
    idle();
    cyc("loaduse_after", NONE);
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    cyc("loaduse_r0", NONE);
    set_in(1, 7, 0, 0, 0, 0, 0, 7, 1, 0, 0, 1);
    cyc("fwd_mem_raw", NONE);
    set_in(1, 4, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1);
    cyc("fwd_exe_alu", NONE);

    set_in(0, 1, 7, 1, 0, 0, 0, 7, 1, 0, 0, 1);
    cyc("raw_mem_src2", STALL);
    set_in(0, 1, 7, 0, 0, 0, 0, 7, 1, 0, 0, 1);
    cyc("raw_mem_one_src", NONE);
    set_in(0, 4, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1);
    cyc("raw_exe", STALL);

    mem(1, 1, 0);
    cyc("mem_hit", NONE);
    mem(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc("mem_wait", FRZ);
    mem(1, 1, 0);
    cyc("mem_ready", NONE);
    mem(1, 0, 0);
    cyc("b2b_enter", FRZ);
    mem(1, 1, 0);
    cyc("b2b_ready", NONE);

    mem(1, 0, 0);
    for (int i = 0; i < 15; i++) cyc("tmo_wait", FRZ);
    cyc("tmo_pulse", TMO);
    idle();
    cyc("tmo_after", NONE);

    set_in(1, 3, 0, 0, 3, 1, 1, 0, 0, 1, 0, 1);
    cyc("branch_hz", FLUSH);
    mem(1, 0, 1);
    cyc("branch_frz1", FRZ);
    cyc("branch_frz2", FRZ);
    mem(1, 1, 1);
    cyc("branch_release", FLUSH);
    idle();
    cyc("branch_after", NONE);

    mem(1, 0, 0);
    for (int i = 0; i < 5; i++) cyc("rst_pre", FRZ);
    rst_n = 1'b0;
    #1;
    check("rst_freeze", {31'd0, freeze}, 32'd0);
    check("rst_cnt", {16'd0, stall_cycles}, 32'd0);
    exp_cnt = '0;
    cyc("rst_hold", NONE);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) cyc("rst_tmo_wait", FRZ);
    cyc("rst_tmo_pulse", TMO);
    idle();
    cyc("rst_tmo_after", NONE);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Detects load-use and, with forwarding disabled, RAW hazards between ID and EXE/MEM.
- Freezes the pipeline while the data memory is not ready, with a timeout.
- Issues flushes on taken branches.
- Sits beside the ForwardingUnit and drives the pipeline register enables/clears.

Parameters:
REG_ADDR_W, 5, register file address width (equals REG_FILE_ADDR_LEN from defines)
MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before forced release (>=2)
CNT_W, 16, width of stall performance counter

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
fwd_en  input  1  1 = forwarding active (only load-use stalls), 0 = stall on any RAW
src1_ID  input  REG_ADDR_W  first source register of ID instruction
src2_ID  input  REG_ADDR_W  second source register of ID instruction
two_src_ID  input  1  ID instruction reads src2_ID
dest_EXE  input  REG_ADDR_W  destination of EXE instruction
WB_EN_EXE  input  1  EXE instruction writes back
MEM_R_EN_EXE  input  1  EXE instruction is a load
dest_MEM  input  REG_ADDR_W  destination of MEM instruction
WB_EN_MEM  input  1  MEM instruction writes back
branch_taken_EXE  input  1  branch resolved taken in EXE
mem_req_MEM  input  1  MEM stage accessing data memory
mem_ready  input  1  data memory completes access this cycle
stall_IF  output  1  hold PC
stall_ID  output  1  hold IF/ID register
bubble_EXE  output  1  load NOP into ID/EXE register
freeze  output  1  hold all pipeline registers (ID/EXE, EXE/MEM, MEM/WB included)
flush_IF_ID  output  1  clear IF/ID register
flush_ID_EXE  output  1  clear ID/EXE register
mem_timeout  output  1  one-cycle pulse on forced memory release
stall_cycles  output  CNT_W  count of cycles with stall_IF=1, saturating

Behaviour:
Reset (rst_n=0, async):
- state=RUN, wait_cnt=0, stall_cycles=0, mem_timeout=0.
- All combinational outputs evaluate to 0 while in reset.

Hazard term (combinational). Register 0 never matches. Let mE = src1_ID==dest_EXE || (two_src_ID && src2_ID==dest_EXE), and mM likewise against dest_MEM.
- fwd_en=1: hz = WB_EN_EXE && MEM_R_EN_EXE && mE.
- fwd_en=0: hz = (WB_EN_EXE && mE) || (WB_EN_MEM && mM).

FSM states: RUN, MEM_WAIT.
- RUN:
  - If mem_req_MEM && !mem_ready: freeze=1 this cycle; next state MEM_WAIT; wait_cnt<=1.
  - Otherwise freeze=0.
- MEM_WAIT:
  - freeze = !mem_ready.
  - If mem_ready: freeze=0, next state RUN, wait_cnt<=0.
  - Else if wait_cnt==MEM_TIMEOUT-1: freeze=0, mem_timeout=1 (registered pulse visible in the same cycle via combinational decode of state/count), next state RUN, wait_cnt<=0.
  - Else wait_cnt<=wait_cnt+1.

Output priority, evaluated each cycle:
1. freeze=1: stall_IF=stall_ID=1, bubble_EXE=0, flush_IF_ID=flush_ID_EXE=0. A branch held in EXE is acted on when the freeze drops.
2. branch_taken_EXE=1: flush_IF_ID=flush_ID_EXE=1, stall_IF=stall_ID=bubble_EXE=0. A hazard on a wrong-path ID instruction is ignored.
3. hz=1: stall_IF=stall_ID=1, bubble_EXE=1.
4. Otherwise all 0.

stall_cycles:
- Increments on each clk edge where stall_IF=1.
- Holds at 2^CNT_W-1.

Timing and boundaries:
- Latency: hazard, flush and freeze outputs respond in the same cycle as their inputs. Only the FSM, wait_cnt and the counter are registered.
- Back-to-back memory accesses: a new mem_req_MEM && !mem_ready in the cycle after return to RUN re-enters MEM_WAIT normally.
- rst_n asserted mid-MEM_WAIT: immediate return to RUN, freeze drops asynchronously.

Test Plan:
- fwd_en=1, EXE load to r3 (MEM_R_EN_EXE=1, WB_EN_EXE=1, dest_EXE=3), src1_ID=3 -> stall_IF=stall_ID=bubble_EXE=1 for exactly 1 cycle; stall_cycles=1. Repeat with dest_EXE=0 -> no stall.
- fwd_en=0, WB_EN_MEM=1, dest_MEM=7, two_src_ID=1, src2_ID=7 -> stall+bubble. Same with two_src_ID=0 -> no stall.
- mem_req_MEM=1, mem_ready low for 3 cycles then high -> freeze=1 for 3 cycles, 0 on the ready cycle, state back to RUN, stall_cycles+=3.
- MEM_TIMEOUT=16, mem_ready held low -> freeze=1 for cycles 1..15, then mem_timeout=1 with freeze=0 on the 16th cycle; next cycle mem_timeout=0.
- branch_taken_EXE=1 together with load-use hz=1 -> flush_IF_ID=flush_ID_EXE=1, stall_IF=0, bubble_EXE=0. Branch during freeze -> no flush until the mem_ready cycle, then flush.
- Assert rst_n=0 at MEM_WAIT wait_cnt=5 -> freeze=0 immediately, stall_cycles=0. After release, a fresh request times out after the full 16 cycles.
